seq_detect_param: RTL and testbench

Parametrised serial pattern detector, the next generation of the team's fixed-pattern Mealy sequence detectors.
- Width and pattern set at build time; pattern reloadable at run time.
- Overlapping or non-overlapping detection, selected by parameter.
- Sample-enable qualifier on the serial input.
- Saturating match counter.
- Sits on a serial bitstream path and flags each occurrence of the pattern with a registered one-cycle pulse.

---
 rtl/seq_detect_param.sv | 74 +++++++
 tb/tb_seq_detect_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with registered Mealy match pulse,
// run-time reloadable pattern, optional overlap and saturating match counter.
module seq_detect_param #(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10010,
  parameter bit               REPEAT  = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  data_in,
  input  logic                  pat_load,
  input  logic [PAT_W-1:0]      pat_in,
  input  logic                  cnt_clr,
  output logic                  data_out,
  output logic [CNT_W-1:0]      match_cnt,
  output logic [$clog2(PAT_W):0] fill
);

  localparam int unsigned     FW       = $clog2(PAT_W) + 1;
  localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] cand;
  logic             hit;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cand = {hist, data_in};
    hit  = en && !pat_load && (fill == FILL_MAX) && (cand == pat_reg);
  end

  // A clear coinciding with a hit keeps that hit, so the count restarts at 1.
  always_comb begin
    cnt_nxt = match_cnt;
    if (cnt_clr)
      cnt_nxt = hit ? CNT_W'(1) : '0;
    else if (hit && (match_cnt != '1))
      cnt_nxt = match_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_reg   <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      data_out  <= 1'b0;
      match_cnt <= '0;
    end else begin
      data_out  <= hit;
      match_cnt <= cnt_nxt;
      if (pat_load) begin
        pat_reg <= pat_in;
        hist    <= '0;
        fill    <= '0;
      end else if (fill > FILL_MAX) begin
        fill <= '0;
      end else if (en) begin
        if (hit && !REPEAT) begin
          hist <= '0;
          fill <= '0;
        end else begin
          // Dropping the oldest bit of cand covers PAT_W=2 without a special case.
          hist <= cand[PAT_W-2:0];
          if (fill != FILL_MAX)
            fill <= fill + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations driven in lockstep and
// checked each cycle against a bit-history model, plus literal expectations.
module tb_seq_detect_param;

  logic       clk;
  logic       rst_n, en, data_in, pat_load, cnt_clr;
  logic [4:0] pat_in;

  logic       do_a, do_b, do_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [3:0] fill_a, fill_b, fill_c;

  int total = 0;
  int bad   = 0;

  seq_detect_param u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .data_out(do_a), .match_cnt(cnt_a), .fill(fill_a)
  );

  seq_detect_param #(.REPEAT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .data_out(do_b), .match_cnt(cnt_b), .fill(fill_b)
  );

  seq_detect_param #(.CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .data_out(do_c), .match_cnt(cnt_c), .fill(fill_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: received bits since the last clear, active pattern, outputs.
  bit         mh   [3][5];
  int         mlen [3];
  logic [4:0] mpat [3];
  bit         mout [3];
  int         mcnt [3];
  bit         mrep [3] = '{1'b1, 1'b0, 1'b1};
  int         mmax [3] = '{255, 255, 3};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      bit hit;
      int v;
      hit = 1'b0;
      if (!rst_n) begin
        mlen[k] = 0;
        mpat[k] = 5'b10010;
        mout[k] = 1'b0;
        mcnt[k] = 0;
      end else begin
        if (pat_load) begin
          mpat[k] = pat_in;
          mlen[k] = 0;
        end else if (en) begin
          mh[k][mlen[k]] = data_in;
          mlen[k]++;
          if (mlen[k] == 5) begin
            v = 0;
            for (int j = 0; j < 5; j++) v = v * 2 + int'(mh[k][j]);
            hit = (v == int'(mpat[k]));
            if (hit && !mrep[k]) mlen[k] = 0;
            else begin
              for (int j = 0; j < 4; j++) mh[k][j] = mh[k][j+1];
              mlen[k] = 4;
            end
          end
        end
        mout[k] = hit;
        if (cnt_clr) mcnt[k] = hit ? 1 : 0;
        else if (hit && mcnt[k] < mmax[k]) mcnt[k]++;
      end
    end
  endtask

  task automatic compare_all();
    chk("a.data_out", int'(do_a), int'(mout[0]));
    chk("a.match_cnt", int'(cnt_a), mcnt[0]);
    chk("a.fill", int'(fill_a), mlen[0]);
    chk("b.data_out", int'(do_b), int'(mout[1]));
    chk("b.match_cnt", int'(cnt_b), mcnt[1]);
    chk("b.fill", int'(fill_b), mlen[1]);
    chk("c.data_out", int'(do_c), int'(mout[2]));
    chk("c.match_cnt", int'(cnt_c), mcnt[2]);
    chk("c.fill", int'(fill_c), mlen[2]);
  endtask

  // One clock: drive inputs, advance the model, sample outputs on the falling edge.
  task automatic step(input bit r, input bit e, input bit d, input bit pl,
                      input logic [4:0] pi, input bit cc);
    rst_n = r; en = e; data_in = d; pat_load = pl; pat_in = pi; cnt_clr = cc;
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic bitin(input bit d);
    step(1'b1, 1'b1, d, 1'b0, 5'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'b0, 1'b0);
  endtask

  bit s1 [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    do_reset();
    do_reset();
    chk("reset.fill", int'(fill_a), 0);
    chk("reset.cnt", int'(cnt_a), 0);
    chk("reset.out", int'(do_a), 0);

    // Overlapping vs non-overlapping on 10010010
    for (int i = 0; i < 8; i++) begin
      bitin(s1[i]);
      if (i == 4) begin
        chk("ovl.a.pulse5", int'(do_a), 1);
        chk("ovl.b.pulse5", int'(do_b), 1);
      end
    end
    chk("ovl.a.pulse8", int'(do_a), 1);
    chk("ovl.b.pulse8", int'(do_b), 0);
    chk("ovl.a.cnt", int'(cnt_a), 2);
    chk("ovl.b.cnt", int'(cnt_b), 1);
    chk("ovl.b.fill", int'(fill_b), 3);

    // Idle gap inside a partial match
    do_reset();
    bitin(1'b1); bitin(1'b0); bitin(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("gap.out", int'(do_a), 0);
      chk("gap.fill", int'(fill_a), 3);
    end
    bitin(1'b1);
    bitin(1'b0);
    chk("gap.pulse", int'(do_a), 1);
    chk("gap.cnt", int'(cnt_a), 1);

    // Runtime reload to 11111 with a partial match pending
    do_reset();
    bitin(1'b1); bitin(1'b0); bitin(1'b0);
    chk("reload.fill_pre", int'(fill_a), 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'b11111, 1'b0);
    chk("reload.fill", int'(fill_a), 0);
    chk("reload.out", int'(do_a), 0);
    for (int i = 1; i <= 7; i++) begin
      bitin(1'b1);
      chk("reload.pulse", int'(do_a), (i >= 5) ? 1 : 0);
    end
    chk("reload.cnt", int'(cnt_a), 3);

    // Clear without a hit, then saturation of the 2-bit counter
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1);
    chk("clr.c.cnt", int'(cnt_c), 0);
    for (int i = 1; i <= 6; i++) begin
      bitin(1'b1);
      chk("sat.c.cnt", int'(cnt_c), (i < 3) ? i : 3);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'b0, 1'b1);
    chk("clrhit.c.cnt", int'(cnt_c), 1);
    chk("clrhit.a.cnt", int'(cnt_a), 1);

    // Reset mid-pattern loses history and restores the default pattern
    bitin(1'b1); bitin(1'b0); bitin(1'b0); bitin(1'b1);
    do_reset();
    bitin(1'b0);
    chk("midrst.out", int'(do_a), 0);
    chk("midrst.fill", int'(fill_a), 1);
    bitin(1'b1); bitin(1'b0); bitin(1'b0); bitin(1'b1);
    chk("midrst.nopulse", int'(do_a), 0);
    bitin(1'b0);
    chk("midrst.pulse", int'(do_a), 1);
    chk("midrst.cnt", int'(cnt_a), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
